// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a frame-coherent double
// buffer, per-digit blink, PWM brightness and anti-ghosting guard blanking.
module seg_scan_driver #(
  parameter int DIGITS       = 6,
  parameter int SEG_W        = 7,
  parameter int SCAN_LOG2    = 10,
  parameter int BRIGHT_W     = 2,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int SEG_ACT_LOW  = 0,
  parameter int DIG_ACT_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DIGITS*SEG_W-1:0]   seg_data,
  input  logic [DIGITS-1:0]         blink_mask,
  input  logic [BRIGHT_W-1:0]       bright,
  input  logic                      enable,
  output logic [SEG_W-1:0]          seg_out,
  output logic [DIGITS-1:0]         dig_en,
  output logic                      frame_start
);

  localparam int DIG_W = $clog2(DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SCAN_LOG2-1:0] PRE_MAX  = {SCAN_LOG2{1'b1}};
  localparam logic [SCAN_LOG2-1:0] GUARD_V  = SCAN_LOG2'(GUARD);
  localparam logic [DIG_W-1:0]     DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [FC_W-1:0]      FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [BRIGHT_W-1:0]  BR_FULL  = {BRIGHT_W{1'b1}};
  localparam logic [DIGITS-1:0]    DIG_ONE  = {{(DIGITS-1){1'b0}}, 1'b1};
  localparam logic [SEG_W-1:0]     SEG_OFF  = (SEG_ACT_LOW != 0) ? {SEG_W{1'b1}}  : {SEG_W{1'b0}};
  localparam logic [DIGITS-1:0]    DIG_OFF  = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [SCAN_LOG2-1:0]    pre_cnt_r;
  logic [DIG_W-1:0]        dig_idx_r;
  logic [FC_W-1:0]         frame_cnt_r;
  logic                    blink_on_r;
  logic [DIGITS*SEG_W-1:0] stg_data_r;
  logic [DIGITS-1:0]       stg_mask_r;
  logic                    pending_r;
  logic [DIGITS*SEG_W-1:0] act_data_r;
  logic [DIGITS-1:0]       act_mask_r;

  logic                    slot_tick_s;
  logic                    frame_wrap_s;
  logic [BRIGHT_W-1:0]     hi_s;
  logic                    lit_s;
  logic [SEG_W-1:0]        cur_seg_s;
  logic [SEG_W-1:0]        seg_nxt_s;
  logic [DIGITS-1:0]       dig_nxt_s;

  // Slot/frame events and the un-mapped drive values for the current scan position.
  always_comb begin
    slot_tick_s  = 1'b0;
    frame_wrap_s = 1'b0;
    hi_s         = pre_cnt_r[SCAN_LOG2-1 -: BRIGHT_W];
    lit_s        = 1'b0;
    cur_seg_s    = act_data_r[dig_idx_r*SEG_W +: SEG_W];
    seg_nxt_s    = {SEG_W{1'b0}};
    dig_nxt_s    = {DIGITS{1'b0}};

    slot_tick_s  = (pre_cnt_r == PRE_MAX);
    frame_wrap_s = slot_tick_s && (dig_idx_r == DIG_LAST);

    // Guard blanking wins over brightness so the commons settle between digits.
    if (pre_cnt_r < GUARD_V) begin
      lit_s = 1'b0;
    end else if (bright == BR_FULL) begin
      lit_s = 1'b1;
    end else begin
      lit_s = (hi_s < bright);
    end

    if (enable && lit_s) begin
      dig_nxt_s = DIG_ONE << dig_idx_r;
      if (act_mask_r[dig_idx_r] && !blink_on_r) begin
        seg_nxt_s = {SEG_W{1'b0}};
      end else begin
        seg_nxt_s = cur_seg_s;
      end
    end else begin
      dig_nxt_s = {DIGITS{1'b0}};
      seg_nxt_s = {SEG_W{1'b0}};
    end
  end

  // Free-running scan counters and blink timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r   <= {SCAN_LOG2{1'b0}};
      dig_idx_r   <= {DIG_W{1'b0}};
      frame_cnt_r <= {FC_W{1'b0}};
      blink_on_r  <= 1'b1;
    end else begin
      pre_cnt_r <= pre_cnt_r + SCAN_LOG2'(1);
      if (slot_tick_s) begin
        if (dig_idx_r == DIG_LAST) begin
          dig_idx_r <= {DIG_W{1'b0}};
        end else begin
          dig_idx_r <= dig_idx_r + DIG_W'(1);
        end
      end
      if (frame_wrap_s) begin
        if (frame_cnt_r == FC_LAST) begin
          frame_cnt_r <= {FC_W{1'b0}};
          blink_on_r  <= ~blink_on_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FC_W'(1);
        end
      end
    end
  end

  // Double buffer: staged copy swaps into active only on the frame wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data_r <= {(DIGITS*SEG_W){1'b0}};
      stg_mask_r <= {DIGITS{1'b0}};
      pending_r  <= 1'b0;
      act_data_r <= {(DIGITS*SEG_W){1'b0}};
      act_mask_r <= {DIGITS{1'b0}};
    end else begin
      if (frame_wrap_s && pending_r) begin
        act_data_r <= stg_data_r;
        act_mask_r <= stg_mask_r;
        pending_r  <= 1'b0;
      end
      // A load on the wrap edge lands in staged only and keeps pending set.
      if (load) begin
        stg_data_r <= seg_data;
        stg_mask_r <= blink_mask;
        pending_r  <= 1'b1;
      end
    end
  end

  // Registered, polarity-mapped pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out     <= SEG_OFF;
      dig_en      <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_nxt_s ^ SEG_OFF;
      dig_en      <= dig_nxt_s ^ DIG_OFF;
      frame_start <= (dig_idx_r == {DIG_W{1'b0}}) && (pre_cnt_r == {SCAN_LOG2{1'b0}});
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-time reference model pushes
// expected pin values each clock, a monitor pops and compares them.
module tb_seg_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SEG_W        = 7;
  localparam int SCAN_LOG2    = 4;
  localparam int BRIGHT_W     = 2;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT         = 1 << SCAN_LOG2;
  localparam int FRAME        = SLOT * DIGITS;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    load = 1'b0;
  logic [DIGITS*SEG_W-1:0] seg_data = '0;
  logic [DIGITS-1:0]       blink_mask = '0;
  logic [BRIGHT_W-1:0]     bright = '0;
  logic                    enable = 1'b0;
  logic [SEG_W-1:0]        seg_out;
  logic [DIGITS-1:0]       dig_en;
  logic                    frame_start;

  seg_scan_driver #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .SCAN_LOG2(SCAN_LOG2), .BRIGHT_W(BRIGHT_W),
    .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES), .SEG_ACT_LOW(0), .DIG_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seg_data(seg_data),
    .blink_mask(blink_mask), .bright(bright), .enable(enable),
    .seg_out(seg_out), .dig_en(dig_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      t;
    logic [DIGITS*SEG_W-1:0] data;
    logic [DIGITS-1:0]       mask;
  } load_t;

  typedef struct {
    logic [SEG_W-1:0]  seg;
    logic [DIGITS-1:0] dig;
    logic              fs;
  } exp_t;

  load_t loads[$];
  exp_t  sb[$];
  int    t_now = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t_now, act, exp);
    end
  endtask

  // Reference model: clock t after reset release shows slot t%16 of digit
  // (t/16)%4 in frame t/64; frame F displays the last load made at t <= 64F-2.
  initial begin
    exp_t e;
    int s, d, f, lim;
    bit lit, blink_on;
    logic [DIGITS*SEG_W-1:0] ad;
    logic [DIGITS-1:0] am;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        e.seg = '0;
        e.dig = '1;
        e.fs  = 1'b0;
        sb.push_back(e);
        loads.delete();
        t_now = 0;
      end else begin
        s   = t_now % SLOT;
        d   = (t_now / SLOT) % DIGITS;
        f   = t_now / FRAME;
        lim = f * FRAME - 2;
        ad  = '0;
        am  = '0;
        foreach (loads[i]) begin
          if (loads[i].t <= lim) begin
            ad = loads[i].data;
            am = loads[i].mask;
          end
        end
        lit      = (s >= GUARD) && ((int'(bright) == 3) || ((s / 4) < int'(bright)));
        blink_on = ((f / BLINK_FRAMES) % 2) == 0;
        e.dig = ~((enable && lit) ? (4'b0001 << d) : 4'b0000);
        e.seg = (enable && lit && !(am[d] && !blink_on)) ? ad[d*SEG_W +: SEG_W] : 7'h00;
        e.fs  = (s == 0) && (d == 0);
        sb.push_back(e);
        if (load) loads.push_back('{t_now, seg_data, blink_mask});
        t_now = t_now + 1;
      end
    end
  end

  // Monitor: the DUT presents a new registered output every clock.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seg_out",     32'(seg_out),     32'(e.seg));
        check("dig_en",      32'(dig_en),      32'(e.dig));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  task automatic goto(input int tt);
    int n = 0;
    while (t_now < tt && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("goto_cycle", 32'(t_now), 32'(tt));
  endtask

  task automatic do_load(input int tt, input logic [DIGITS*SEG_W-1:0] d, input logic [DIGITS-1:0] m);
    goto(tt);
    seg_data   = d;
    blink_mask = m;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  function automatic logic [DIGITS*SEG_W-1:0] rnd_data();
    logic [31:0] r;
    r = $urandom();
    return r[DIGITS*SEG_W-1:0];
  endfunction

  initial begin
    int base;
    logic [31:0] r;
    enable = 1'b1;
    bright = 2'd3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fixed pattern, full brightness; shown from frame 1.
    do_load(0, {7'h08, 7'h04, 7'h02, 7'h01}, 4'b0000);
    goto(2 * FRAME);  bright = 2'd1;
    goto(3 * FRAME);  bright = 2'd0;
    goto(4 * FRAME);  bright = 2'd3;

    // Mid-frame loads (digit 2, then digit 3), then a load on the wrap edge.
    do_load(4 * FRAME + 37, rnd_data(), 4'b0000);
    do_load(4 * FRAME + 51, rnd_data(), 4'b0000);
    do_load(6 * FRAME - 1,  rnd_data(), 4'b0010);
    goto(12 * FRAME);

    // Enable dropped mid-slot and restored later.
    goto(12 * FRAME + 23);  enable = 1'b0;
    goto(14 * FRAME + 41);  enable = 1'b1;

    // Randomised traffic.
    while (t_now < 40 * FRAME) begin
      @(negedge clk);
      r = $urandom();
      load = (r[5:0] == 6'd0);
      if (load) begin
        seg_data   = rnd_data();
        blink_mask = r[11:8];
      end
      if (r[19:14] == 6'd0) bright = r[21:20];
      if (r[29:24] == 6'd0) enable = ~enable;
    end
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    bright = 2'd3;

    // Asynchronous reset mid-frame while a load is pending.
    base = ((t_now / FRAME) + 1) * FRAME;
    do_load(base + 10, rnd_data(), 4'b0000);
    goto(base + 20);
    #1 rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg_out), 32'h0);
    check("async_dig", 32'(dig_en), 32'hF);
    check("async_fs",  32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(3 * FRAME + 5);
    do_load(3 * FRAME + 5, rnd_data(), 4'b1001);
    goto(8 * FRAME);

    @(negedge clk);
    #2;
    check("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
